// File: rtl/output_deskew_buffer.sv
// rtl/output_deskew_buffer.sv - removes column skew from systolic array partial sums and queues aligned rows in a FWFT FIFO

module output_deskew_buffer #(
    parameter int ARRAYWIDTH = 8,
    parameter int PSUMSIZE   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 in_valid,
    input  logic [ARRAYWIDTH*PSUMSIZE-1:0]       in_psum,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ARRAYWIDTH*PSUMSIZE-1:0]       out_psum,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic                                 overflow
);

    localparam int W  = ARRAYWIDTH;
    localparam int P  = PSUMSIZE;
    localparam int RW = W * P;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // Row as seen at the output of the per-column delay lines; all columns
    // belong to the same row in the cycle the valid pipe output is high.
    logic [RW-1:0] aligned_row;

    // Column j arrives j cycles after column 0, so it is held W-1-j cycles to
    // line up with the last column, which takes the direct path.
    for (genvar j = 0; j < W; j++) begin : g_col
        localparam int D = W - 1 - j;
        if (D == 0) begin : g_direct
            assign aligned_row[j*P +: P] = in_psum[j*P +: P];
        end else begin : g_dl
            logic [P-1:0] dl_q [D];

            // Free-running shift register; data is qualified by the valid pipe only.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < D; k++) begin
                        dl_q[k] <= '0;
                    end
                end else begin
                    dl_q[0] <= in_psum[j*P +: P];
                    for (int k = 1; k < D; k++) begin
                        dl_q[k] <= dl_q[k-1];
                    end
                end
            end

            assign aligned_row[j*P +: P] = dl_q[D-1];
        end
    end

    logic [W-2:0]   vpipe_q, vpipe_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [RW-1:0]  mem_q [FIFO_DEPTH];

    logic push_req;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign push_req = vpipe_q[W-2];
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = out_valid & out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Next-state for valid pipe, pointers, occupancy and sticky overflow; clear wins.
    always_comb begin
        vpipe_d  = vpipe_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        vpipe_d[0] = in_valid;
        for (int k = 1; k < W - 1; k++) begin
            vpipe_d[k] = vpipe_q[k-1];
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        if (clear) begin
            vpipe_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            vpipe_q  <= vpipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Row storage; a clearing edge discards the row arriving with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (push && !clear) begin
            mem_q[wr_ptr_q] <= aligned_row;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_psum   = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_output_deskew_buffer.sv
// tb/tb_output_deskew_buffer.sv - self-checking bench for output_deskew_buffer

module tb_output_deskew_buffer;

    localparam int W     = 4;
    localparam int P     = 32;
    localparam int DEPTH = 4;
    localparam int RW    = W * P;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic [RW-1:0] in_psum;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_psum;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    output_deskew_buffer #(
        .ARRAYWIDTH (W),
        .PSUMSIZE   (P),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_psum    (in_psum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_psum   (out_psum),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            start;
        logic [RW-1:0] data;
        bit            killed;
    } pend_t;

    typedef struct {
        int   nrows;
        int   gap;
        logic rdy;
        int   exp_count;
        logic exp_ovf;
    } vec_t;

    pend_t         pq[$];
    logic [RW-1:0] mq[$];
    logic          movf;
    int            edge_n;
    int            n_tests;
    int            n_fail;
    int            seen_valid;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [RW-1:0] mk(input int s, input int r);
        logic [RW-1:0] d;
        for (int j = 0; j < W; j++) begin
            d[j*P +: P] = 32'((s << 16) | (r << 4) | j);
        end
        return d;
    endfunction

    task automatic add_row(input logic [RW-1:0] d);
        pend_t p;
        p.start  = edge_n + 1;
        p.data   = d;
        p.killed = 1'b0;
        pq.push_back(p);
    endtask

    // One clock: drive skewed inputs, advance the model at the edge, then compare.
    task automatic tick(input logic clr, input logic rdy);
        int            nxt;
        int            k;
        logic          v;
        logic [RW-1:0] ps;
        logic          arrive;
        logic [RW-1:0] adata;
        nxt = edge_n + 1;
        v   = 1'b0;
        for (int j = 0; j < W; j++) ps[j*P +: P] = 32'hDEAD;
        foreach (pq[i]) begin
            k = nxt - pq[i].start;
            if (k >= 0 && k < W) begin
                ps[k*P +: P] = pq[i].data[k*P +: P];
                if (k == 0) v = 1'b1;
            end
        end
        clear     = clr;
        out_ready = rdy;
        in_valid  = v;
        in_psum   = ps;
        @(posedge clk);
        edge_n = nxt;
        if (clr) begin
            mq.delete();
            movf = 1'b0;
            foreach (pq[i]) if (pq[i].start <= edge_n) pq[i].killed = 1'b1;
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            arrive = 1'b0;
            adata  = '0;
            foreach (pq[i]) begin
                if (!pq[i].killed && pq[i].start + W - 1 == edge_n) begin
                    arrive = 1'b1;
                    adata  = pq[i].data;
                end
            end
            if (arrive) begin
                if (mq.size() < DEPTH) mq.push_back(adata);
                else movf = 1'b1;
            end
        end
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].start + W - 1 <= edge_n) pq.delete(i);
        end
        #1;
        if (out_valid === 1'b1) seen_valid++;
        chk("out_valid", RW'(out_valid), RW'(mq.size() != 0));
        chk("fifo_count", RW'(fifo_count), RW'(mq.size()));
        chk("overflow", RW'(overflow), RW'(movf));
        if (mq.size() != 0) chk("out_psum", out_psum, mq[0]);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && mq.size() != 0; i++) tick(1'b0, 1'b1);
        chk("drain_empty", RW'(fifo_count), RW'(0));
    endtask

    vec_t vec[6];

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        edge_n     = 0;
        movf       = 1'b0;
        seen_valid = 0;
        rst        = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_psum    = '0;
        out_ready  = 1'b0;

        vec[0] = '{nrows: 1, gap: 0, rdy: 1'b1, exp_count: 0, exp_ovf: 1'b0};
        vec[1] = '{nrows: 4, gap: 0, rdy: 1'b1, exp_count: 0, exp_ovf: 1'b0};
        vec[2] = '{nrows: 5, gap: 0, rdy: 1'b0, exp_count: 4, exp_ovf: 1'b1};
        vec[3] = '{nrows: 3, gap: 1, rdy: 1'b0, exp_count: 3, exp_ovf: 1'b0};
        vec[4] = '{nrows: 4, gap: 0, rdy: 1'b0, exp_count: 4, exp_ovf: 1'b0};
        vec[5] = '{nrows: 6, gap: 2, rdy: 1'b0, exp_count: 4, exp_ovf: 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", RW'(out_valid), RW'(0));
        chk("rst_out_psum", out_psum, RW'(0));
        chk("rst_fifo_count", RW'(fifo_count), RW'(0));
        chk("rst_overflow", RW'(overflow), RW'(0));
        rst = 1'b1;

        // Table-driven scenarios: single row, back-to-back, backpressure, overflow
        for (int s = 0; s < 6; s++) begin
            for (int r = 0; r < vec[s].nrows; r++) begin
                add_row(mk(s + 1, r));
                tick(1'b0, vec[s].rdy);
                repeat (vec[s].gap) tick(1'b0, vec[s].rdy);
            end
            repeat (W + 1) tick(1'b0, vec[s].rdy);
            chk($sformatf("vec%0d_count", s), RW'(fifo_count), RW'(vec[s].exp_count));
            chk($sformatf("vec%0d_ovf", s), RW'(overflow), RW'(vec[s].exp_ovf));
            drain();
            chk($sformatf("vec%0d_ovf_held", s), RW'(overflow), RW'(vec[s].exp_ovf));
            tick(1'b1, 1'b0);
        end

        // Full FIFO with a pop on the same edge the fifth row is written
        for (int t = 0; t < 10; t++) begin
            if (t < 5) add_row(mk(10, t));
            tick(1'b0, t == 7);
        end
        chk("full_pop_count", RW'(fifo_count), RW'(4));
        chk("full_pop_ovf", RW'(overflow), RW'(0));
        chk("full_pop_head", out_psum, mk(10, 1));
        drain();
        tick(1'b1, 1'b0);

        // Clear while a row is in flight
        seen_valid = 0;
        add_row(mk(11, 0));
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        add_row(mk(11, 1));
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("clr_no_ghost", RW'(out_valid), RW'(0));
        tick(1'b0, 1'b1);
        chk("clr_new_valid", RW'(out_valid), RW'(1));
        chk("clr_new_data", out_psum, mk(11, 1));
        repeat (3) tick(1'b0, 1'b1);
        chk("clr_valid_cycles", RW'(seen_valid), RW'(1));

        // Asynchronous reset between edges with two rows held
        add_row(mk(12, 0));
        tick(1'b0, 1'b0);
        add_row(mk(12, 1));
        repeat (5) tick(1'b0, 1'b0);
        chk("arst_pre_count", RW'(fifo_count), RW'(2));
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", RW'(out_valid), RW'(0));
        chk("arst_fifo_count", RW'(fifo_count), RW'(0));
        chk("arst_overflow", RW'(overflow), RW'(0));
        chk("arst_out_psum", out_psum, RW'(0));
        pq.delete();
        mq.delete();
        movf = 1'b0;
        #2 rst = 1'b1;
        add_row(mk(12, 2));
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("arst_latency_early", RW'(out_valid), RW'(0));
        tick(1'b0, 1'b1);
        chk("arst_latency_valid", RW'(out_valid), RW'(1));
        chk("arst_latency_data", out_psum, mk(12, 2));
        repeat (3) tick(1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
